// File: rtl/fan_off_timer.sv
// Fan sleep timer: minutes loaded by button pulses, counted down
// as min:sec:msec on a 1 ms tick; gates the fan off on expiry.
module fan_off_timer #(
  parameter int unsigned TICKS_PER_MS = 100000,
  parameter int unsigned MAX_MIN      = 99
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_add_min,
  input  logic       i_start,
  input  logic       i_cancel,
  output logic [6:0] o_min,
  output logic [6:0] o_sec,
  output logic [6:0] o_msec,
  output logic       o_fan_en,
  output logic       o_expired,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned PW =
    (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [6:0]    MAX_M   = 7'(MAX_MIN);

  state_e        state_q, state_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [9:0]    msec_q, msec_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          exp_q, exp_d;
  logic          fan_q, fan_d;
  logic [6:0]    min_nxt;
  logic          tick;

  assign tick = (ps_q == PS_LAST);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    msec_d  = msec_q;
    ps_d    = '0;
    exp_d   = 1'b0;
    min_nxt = min_q;
    unique case (state_q)
      IDLE: begin
        if (i_add_min) begin
          state_d = SET;
          min_d   = 7'd1;
          sec_d   = '0;
          msec_d  = '0;
        end
      end
      SET: begin
        if (i_cancel) begin
          state_d = IDLE;
          min_d   = '0;
          sec_d   = '0;
          msec_d  = '0;
        end else if (i_start) begin
          state_d = RUN;
        end else if (i_add_min && min_q < MAX_M) begin
          min_d = min_q + 7'd1;
        end
      end
      RUN: begin
        if (i_cancel) begin
          state_d = IDLE;
          min_d   = '0;
          sec_d   = '0;
          msec_d  = '0;
        end else begin
          ps_d = tick ? '0 : ps_q + PW'(1);
          if (tick) begin
            if (msec_q != 10'd0) begin
              msec_d = msec_q - 10'd1;
            end else if (sec_q != 6'd0) begin
              msec_d = 10'd999;
              sec_d  = sec_q - 6'd1;
            end else if (min_q != 7'd0) begin
              msec_d  = 10'd999;
              sec_d   = 6'd59;
              min_nxt = min_q - 7'd1;
            end else begin
              state_d = DONE;
              exp_d   = 1'b1;
            end
          end
          // borrow is applied first so a coincident add nets to zero
          if (i_add_min && !exp_d && min_nxt < MAX_M) begin
            min_d = min_nxt + 7'd1;
          end else begin
            min_d = min_nxt;
          end
        end
      end
      DONE: begin
        if (i_cancel) begin
          state_d = IDLE;
        end else if (i_add_min) begin
          state_d = SET;
          min_d   = 7'd1;
        end
      end
    endcase
    fan_d = (state_d != DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      msec_q  <= '0;
      ps_q    <= '0;
      exp_q   <= 1'b0;
      fan_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      msec_q  <= msec_d;
      ps_q    <= ps_d;
      exp_q   <= exp_d;
      fan_q   <= fan_d;
    end
  end

  assign o_min     = min_q;
  assign o_sec     = {1'b0, sec_q};
  assign o_msec    = 7'(msec_q / 10'd10);
  assign o_fan_en  = fan_q;
  assign o_expired = exp_q;
  assign o_state   = state_q;

endmodule
